// File: rtl/ras_pkg.sv
// Shared sizing for the return address stack: depth, stored target width and
// the derived pointer/count widths.
package ras_pkg;

  localparam int RAS_DEPTH        = 8;
  localparam int RAS_TARGET_WIDTH = 12;
  localparam int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH);
  localparam int RAS_COUNT_WIDTH  = $clog2(RAS_DEPTH + 1);

  typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;
  typedef logic [LOG_RAS_DEPTH-1:0]    ras_index_t;
  typedef logic [RAS_COUNT_WIDTH-1:0]  ras_count_t;

endpackage

// File: rtl/ras_if.sv
// Prediction and restore signal bundle between the fetch-predict front end
// (master) and the return address stack (slave).
interface ras_if;
  import ras_pkg::*;

  logic        pred_push;
  ras_target_t pred_push_target;
  logic        pred_pop;
  logic        pred_ret_valid;
  ras_target_t pred_ret_target;
  ras_index_t  pred_ras_index;
  ras_count_t  pred_ras_count;
  logic        restore_valid;
  ras_index_t  restore_ras_index;
  ras_count_t  restore_ras_count;
  logic        restore_repair_valid;
  ras_target_t restore_repair_target;

  modport master (
    output pred_push, pred_push_target, pred_pop,
    output restore_valid, restore_ras_index, restore_ras_count,
    output restore_repair_valid, restore_repair_target,
    input  pred_ret_valid, pred_ret_target, pred_ras_index, pred_ras_count
  );

  modport slave (
    input  pred_push, pred_push_target, pred_pop,
    input  restore_valid, restore_ras_index, restore_ras_count,
    input  restore_repair_valid, restore_repair_target,
    output pred_ret_valid, pred_ret_target, pred_ras_index, pred_ras_count
  );

endinterface

// File: rtl/ras.sv
// Return address stack: circular flop array with a wrapping top pointer and a
// saturating valid count; exports top/count as a checkpoint for restore.
module ras
  import ras_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  ras_if.slave bus
);

  ras_target_t stack [RAS_DEPTH];
  ras_index_t  top;
  ras_count_t  count;

  ras_index_t  top_inc;
  ras_index_t  top_dec;
  logic        count_full;
  logic        count_empty;

  assign top_inc     = top + LOG_RAS_DEPTH'(1);
  assign top_dec     = top - LOG_RAS_DEPTH'(1);
  assign count_full  = (count == RAS_COUNT_WIDTH'(RAS_DEPTH));
  assign count_empty = (count == '0);

  assign bus.pred_ret_target = stack[top];
  assign bus.pred_ret_valid  = !count_empty;
  assign bus.pred_ras_index  = top;
  assign bus.pred_ras_count  = count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
      top   <= LOG_RAS_DEPTH'(RAS_DEPTH - 1);
      count <= '0;
    end else if (bus.restore_valid) begin
      top   <= bus.restore_ras_index;
      count <= bus.restore_ras_count;
      if (bus.restore_repair_valid)
        stack[bus.restore_ras_index] <= bus.restore_repair_target;
    end else if (bus.pred_push && bus.pred_pop) begin
      // call and return in one cycle: replace the top, depth unchanged
      stack[top] <= bus.pred_push_target;
    end else if (bus.pred_push) begin
      top            <= top_inc;
      stack[top_inc] <= bus.pred_push_target;
      if (!count_full) count <= count + RAS_COUNT_WIDTH'(1);
    end else if (bus.pred_pop) begin
      // pop on empty still walks top so a later restore sees a consistent pointer
      top <= top_dec;
      if (!count_empty) count <= count - RAS_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed scenarios plus randomized traffic
// compared against a behavioural stack model.
module tb_ras;
  import ras_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ras_if ifc ();

  ras dut (.CLK(CLK), .RST(RST), .bus(ifc.slave));

  always #5 CLK = ~CLK;

  int m_stack [RAS_DEPTH];
  int m_top;
  int m_count;

  task automatic model_reset();
    for (int i = 0; i < RAS_DEPTH; i++) m_stack[i] = 0;
    m_top   = RAS_DEPTH - 1;
    m_count = 0;
  endtask

  task automatic model_apply(input bit push, input bit pop, input int tgt,
                             input bit rv, input int ri, input int rc,
                             input bit rrv, input int rrt);
    if (rv) begin
      m_top   = ri;
      m_count = rc;
      if (rrv) m_stack[ri] = rrt;
    end else if (push && pop) begin
      m_stack[m_top] = tgt;
    end else if (push) begin
      m_top = (m_top + 1) % RAS_DEPTH;
      m_stack[m_top] = tgt;
      m_count = (m_count < RAS_DEPTH) ? m_count + 1 : RAS_DEPTH;
    end else if (pop) begin
      m_top = (m_top + RAS_DEPTH - 1) % RAS_DEPTH;
      m_count = (m_count > 0) ? m_count - 1 : 0;
    end
  endtask

  task automatic set_idle();
    ifc.pred_push = 1'b0;
    ifc.pred_push_target = '0;
    ifc.pred_pop = 1'b0;
    ifc.restore_valid = 1'b0;
    ifc.restore_ras_index = '0;
    ifc.restore_ras_count = '0;
    ifc.restore_repair_valid = 1'b0;
    ifc.restore_repair_target = '0;
    RST = 1'b0;
  endtask

  // One clock of stimulus; model follows the same edge, outputs sampled 1 after.
  task automatic cycle(input bit rst, input bit push, input bit pop, input int tgt,
                       input bit rv, input int ri, input int rc,
                       input bit rrv, input int rrt);
    RST = rst;
    ifc.pred_push = push;
    ifc.pred_push_target = RAS_TARGET_WIDTH'(tgt);
    ifc.pred_pop = pop;
    ifc.restore_valid = rv;
    ifc.restore_ras_index = LOG_RAS_DEPTH'(ri);
    ifc.restore_ras_count = RAS_COUNT_WIDTH'(rc);
    ifc.restore_repair_valid = rrv;
    ifc.restore_repair_target = RAS_TARGET_WIDTH'(rrt);
    @(posedge CLK);
    if (rst) model_reset();
    else model_apply(push, pop, tgt, rv, ri, rc, rrv, rrt);
    #1;
    set_idle();
  endtask

  task automatic do_reset();            cycle(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_push(input int t);  cycle(0, 1, 0, t, 0, 0, 0, 0, 0); endtask
  task automatic do_pop();              cycle(0, 0, 1, 0, 0, 0, 0, 0, 0); endtask

  task automatic test_reset();
    cycle(1, 1, 1, 'h7AA, 1, 2, 3, 1, 'h123);
    checks++;
    if (ifc.pred_ret_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b want 0", ifc.pred_ret_valid);
    end
    checks++;
    if (ifc.pred_ret_target !== 12'h000) begin
      errors++; $display("FAIL reset_target: got %h want 000", ifc.pred_ret_target);
    end
    checks++;
    if (ifc.pred_ras_index !== 3'd7) begin
      errors++; $display("FAIL reset_index: got %0d want 7", ifc.pred_ras_index);
    end
    checks++;
    if (ifc.pred_ras_count !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", ifc.pred_ras_count);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    do_push('h111); do_push('h222); do_push('h333);
    checks++;
    if (ifc.pred_ras_index !== 3'd2 || ifc.pred_ras_count !== 4'd3 ||
        ifc.pred_ret_target !== 12'h333) begin
      errors++;
      $display("FAIL push3: got top=%0d cnt=%0d tgt=%h want top=2 cnt=3 tgt=333",
               ifc.pred_ras_index, ifc.pred_ras_count, ifc.pred_ret_target);
    end
    do_pop(); do_pop();
    checks++;
    if (ifc.pred_ret_target !== 12'h111 || ifc.pred_ras_count !== 4'd1) begin
      errors++;
      $display("FAIL pop2: got tgt=%h cnt=%0d want tgt=111 cnt=1",
               ifc.pred_ret_target, ifc.pred_ras_count);
    end
  endtask

  task automatic test_overflow();
    logic [11:0] last_seen;
    do_reset();
    for (int i = 1; i <= 9; i++) do_push(i);
    checks++;
    if (ifc.pred_ras_count !== 4'd8 || ifc.pred_ras_index !== 3'd0 ||
        ifc.pred_ret_target !== 12'h009) begin
      errors++;
      $display("FAIL overflow: got top=%0d cnt=%0d tgt=%h want top=0 cnt=8 tgt=009",
               ifc.pred_ras_index, ifc.pred_ras_count, ifc.pred_ret_target);
    end
    last_seen = '0;
    for (int i = 0; i < 8; i++) begin
      if (ifc.pred_ret_valid) last_seen = ifc.pred_ret_target;
      do_pop();
    end
    checks++;
    if (last_seen !== 12'h002) begin
      errors++; $display("FAIL overflow_last: got %h want 002", last_seen);
    end
    checks++;
    if (ifc.pred_ret_valid !== 1'b0) begin
      errors++; $display("FAIL overflow_drained_valid: got %0b want 0", ifc.pred_ret_valid);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    do_pop();
    checks++;
    if (ifc.pred_ras_index !== 3'd6 || ifc.pred_ras_count !== 4'd0 ||
        ifc.pred_ret_valid !== 1'b0) begin
      errors++;
      $display("FAIL underflow: got top=%0d cnt=%0d valid=%0b want top=6 cnt=0 valid=0",
               ifc.pred_ras_index, ifc.pred_ras_count, ifc.pred_ret_valid);
    end
    do_push('hABC);
    checks++;
    if (ifc.pred_ras_index !== 3'd7 || ifc.pred_ret_target !== 12'hABC) begin
      errors++;
      $display("FAIL underflow_push: got top=%0d tgt=%h want top=7 tgt=abc",
               ifc.pred_ras_index, ifc.pred_ret_target);
    end
  endtask

  task automatic test_push_pop_same();
    do_reset();
    do_push('h444);
    cycle(0, 1, 1, 'h555, 0, 0, 0, 0, 0);
    checks++;
    if (ifc.pred_ras_index !== 3'd0 || ifc.pred_ras_count !== 4'd1 ||
        ifc.pred_ret_target !== 12'h555) begin
      errors++;
      $display("FAIL push_pop_same: got top=%0d cnt=%0d tgt=%h want top=0 cnt=1 tgt=555",
               ifc.pred_ras_index, ifc.pred_ras_count, ifc.pred_ret_target);
    end
  endtask

  task automatic test_restore_repair();
    do_reset();
    do_push('hA); do_push('hB);
    checks++;
    if (ifc.pred_ras_index !== 3'd1 || ifc.pred_ras_count !== 4'd2) begin
      errors++;
      $display("FAIL checkpoint: got idx=%0d cnt=%0d want idx=1 cnt=2",
               ifc.pred_ras_index, ifc.pred_ras_count);
    end
    do_push('hC); do_pop(); do_pop(); do_push('hD);
    checks++;
    if (ifc.pred_ret_target !== 12'h00D) begin
      errors++; $display("FAIL overwrite_d: got %h want 00d", ifc.pred_ret_target);
    end
    cycle(0, 0, 0, 0, 1, 1, 2, 1, 'hB);
    checks++;
    if (ifc.pred_ras_index !== 3'd1 || ifc.pred_ras_count !== 4'd2 ||
        ifc.pred_ret_target !== 12'h00B) begin
      errors++;
      $display("FAIL restore_repair: got top=%0d cnt=%0d tgt=%h want top=1 cnt=2 tgt=00b",
               ifc.pred_ras_index, ifc.pred_ras_count, ifc.pred_ret_target);
    end
    do_pop();
    checks++;
    if (ifc.pred_ret_target !== 12'h00A) begin
      errors++; $display("FAIL restore_pop: got %h want 00a", ifc.pred_ret_target);
    end
  endtask

  task automatic test_restore_priority();
    cycle(0, 1, 0, 'hFFF, 1, 3, 5, 0, 0);
    checks++;
    if (ifc.pred_ras_index !== 3'd3 || ifc.pred_ras_count !== 4'd5) begin
      errors++;
      $display("FAIL restore_prio: got idx=%0d cnt=%0d want idx=3 cnt=5",
               ifc.pred_ras_index, ifc.pred_ras_count);
    end
    for (int i = 0; i < RAS_DEPTH; i++) begin
      checks++;
      if (ifc.pred_ret_target === 12'hFFF ||
          ifc.pred_ret_target !== RAS_TARGET_WIDTH'(m_stack[m_top])) begin
        errors++;
        $display("FAIL restore_prio_entry%0d: got %h want %h", i,
                 ifc.pred_ret_target, m_stack[m_top]);
      end
      do_pop();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)
        cycle(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 0, 0, 0, 0, 0);
      else if (r < 10)
        cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom & 'hFFF, 1,
              $urandom_range(0, RAS_DEPTH - 1), $urandom_range(0, RAS_DEPTH),
              $urandom_range(0, 1), $urandom & 'hFFF);
      else
        cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom & 'hFFF,
              0, 0, 0, 0, 0);
      checks++;
      if (ifc.pred_ras_index !== LOG_RAS_DEPTH'(m_top) ||
          ifc.pred_ras_count !== RAS_COUNT_WIDTH'(m_count) ||
          ifc.pred_ret_valid !== (m_count != 0) ||
          ifc.pred_ret_target !== RAS_TARGET_WIDTH'(m_stack[m_top])) begin
        errors++;
        $display("FAIL random_%0d: got top=%0d cnt=%0d v=%0b tgt=%h want top=%0d cnt=%0d v=%0b tgt=%h",
                 n, ifc.pred_ras_index, ifc.pred_ras_count, ifc.pred_ret_valid,
                 ifc.pred_ret_target, m_top, m_count, (m_count != 0), m_stack[m_top]);
      end
    end
  endtask

  initial begin
    set_idle();
    model_reset();
    @(negedge CLK);
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_push_pop_same();
    test_restore_repair();
    test_restore_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
